// File: rtl/mac_vector_packer_pkg.sv
// Shared definitions for the MAC vector packer and the multiply_and_accumulate wrappers.
// Holds the float format defaults, the vector count width and the packer states.
package mac_vector_packer_pkg;

    localparam int DEF_FRAC_WIDTH = 24;
    localparam int DEF_EXP_WIDTH  = 8;
    localparam int PACK_CNT_WIDTH = 16;

    localparam logic [DEF_FRAC_WIDTH+DEF_EXP_WIDTH-1:0] FLOAT_ZERO = '0;

    typedef enum logic {
        IDLE,
        FILL
    } pack_state_t;

    function automatic int data_width(input int frac_w, input int exp_w);
        return frac_w + exp_w;
    endfunction

endpackage

// File: rtl/mac_vector_packer.sv
// Serial-to-vector packer feeding multiply_and_accumulate: packs operand pairs into
// VECTOR_SIZE lanes and emits a lane mask, a last flag and a per-product vector count.
module mac_vector_packer
    import mac_vector_packer_pkg::*;
#(
    parameter int FRAC_WIDTH  = DEF_FRAC_WIDTH,
    parameter int EXP_WIDTH   = DEF_EXP_WIDTH,
    parameter int VECTOR_SIZE = 8
) (
    input  logic                                    clkIn,
    input  logic                                    rstIn,
    input  logic [FRAC_WIDTH+EXP_WIDTH-1:0]         dataAIn,
    input  logic [FRAC_WIDTH+EXP_WIDTH-1:0]         dataBIn,
    input  logic                                    validIn,
    input  logic                                    lastIn,
    output logic                                    readyOut,
    output logic [(FRAC_WIDTH+EXP_WIDTH)*VECTOR_SIZE-1:0] dataAOut,
    output logic [(FRAC_WIDTH+EXP_WIDTH)*VECTOR_SIZE-1:0] dataBOut,
    output logic [VECTOR_SIZE-1:0]                  validOut,
    output logic                                    lastOut,
    output logic [PACK_CNT_WIDTH-1:0]               vecCountOut
);

    localparam int DATA_WIDTH = data_width(FRAC_WIDTH, EXP_WIDTH);
    localparam int PTR_W      = $clog2(VECTOR_SIZE);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(VECTOR_SIZE - 1);

    pack_state_t               state;
    logic [PTR_W-1:0]          lane_ptr;
    logic                      ready;
    logic                      last_q;
    logic                      closed;
    logic [PACK_CNT_WIDTH-1:0] vec_cnt;

    logic                   accept;
    logic                   flush;
    logic                   in_fill;
    logic [VECTOR_SIZE-1:0] hit_mask;
    logic [VECTOR_SIZE-1:0] below_mask;

    always_comb begin
        accept     = validIn & ready;
        flush      = accept & ((lane_ptr == LAST_LANE) | lastIn);
        in_fill    = (state == FILL);
        hit_mask   = VECTOR_SIZE'(1) << lane_ptr;
        below_mask = hit_mask - VECTOR_SIZE'(1);
    end

    // A count restarts at 1 on the first flush after a vector that closed a product.
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state    <= IDLE;
            lane_ptr <= '0;
            ready    <= 1'b0;
            last_q   <= 1'b0;
            closed   <= 1'b0;
            vec_cnt  <= '0;
        end else begin
            ready  <= 1'b1;
            last_q <= flush & lastIn;
            if (flush) begin
                state    <= IDLE;
                lane_ptr <= '0;
                closed   <= lastIn;
                if (closed)
                    vec_cnt <= PACK_CNT_WIDTH'(1);
                else if (vec_cnt != '1)
                    vec_cnt <= vec_cnt + 1'b1;
            end else if (accept) begin
                state    <= FILL;
                lane_ptr <= lane_ptr + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < VECTOR_SIZE; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] st_a;
        logic [DATA_WIDTH-1:0] st_b;
        logic [DATA_WIDTH-1:0] out_a;
        logic [DATA_WIDTH-1:0] out_b;
        logic                  out_v;

        always_ff @(posedge clkIn or negedge rstIn) begin
            if (!rstIn) begin
                st_a <= '0;
                st_b <= '0;
            end else if (flush) begin
                st_a <= '0;
                st_b <= '0;
            end else if (accept && hit_mask[i]) begin
                st_a <= dataAIn;
                st_b <= dataBIn;
            end
        end

        // Lanes above the pointer are zeroed so the adder tree sees no contribution.
        always_ff @(posedge clkIn or negedge rstIn) begin
            if (!rstIn) begin
                out_a <= '0;
                out_b <= '0;
                out_v <= 1'b0;
            end else begin
                out_v <= flush & (hit_mask[i] | below_mask[i]);
                if (flush) begin
                    if (hit_mask[i]) begin
                        out_a <= dataAIn;
                        out_b <= dataBIn;
                    end else if (below_mask[i] && in_fill) begin
                        out_a <= st_a;
                        out_b <= st_b;
                    end else begin
                        out_a <= '0;
                        out_b <= '0;
                    end
                end
            end
        end

        assign dataAOut[i*DATA_WIDTH +: DATA_WIDTH] = out_a;
        assign dataBOut[i*DATA_WIDTH +: DATA_WIDTH] = out_b;
        assign validOut[i] = out_v;
    end

    assign readyOut    = ready;
    assign lastOut     = last_q;
    assign vecCountOut = vec_cnt;

endmodule
